// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register file write port between
// the execute and load paths, with a registered write stage and x0 filter.

module rf_wb_lookup #(
    parameter int ADW = 5
) (
    input  logic           rf_we,
    input  logic [ADW-1:0] rf_addr,
    input  logic [ADW-1:0] q_addr,
    output logic           q_hit
);
    // rf_we is never set for x0, so a zero lookup address cannot hit
    assign q_hit = rf_we && (rf_addr == q_addr);
endmodule

module rf_wb_arbiter #(
    parameter int ADW  = 5,
    parameter int DPW  = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [ADW-1:0]  ex_addr,
    input  logic [DPW-1:0]  ex_data,
    output logic            ex_ready,
    input  logic            ld_valid,
    input  logic [ADW-1:0]  ld_addr,
    input  logic [DPW-1:0]  ld_data,
    output logic            ld_ready,
    output logic            rf_we,
    output logic [ADW-1:0]  rf_addr,
    output logic [DPW-1:0]  rf_wd,
    input  logic [ADW-1:0]  q_addr_1,
    input  logic [ADW-1:0]  q_addr_2,
    output logic            q_hit_1,
    output logic            q_hit_2,
    output logic [DPW-1:0]  fwd_data,
    output logic [CNTW-1:0] cont_cnt
);
    localparam int NUM_Q = 2;

    typedef struct packed {
        logic [ADW-1:0] addr;
        logic [DPW-1:0] data;
    } wb_req_t;

    logic    prio;          // 0: load favoured, 1: execute favoured
    logic    both_valid;
    logic    grant;
    wb_req_t sel;

    logic [NUM_Q-1:0][ADW-1:0] q_addr;
    logic [NUM_Q-1:0]          q_hit;

    assign both_valid = ex_valid && ld_valid;

    // Grants depend only on the valids, prio and reset
    assign ex_ready = !rst && ex_valid && (!ld_valid || prio);
    assign ld_ready = !rst && ld_valid && (!ex_valid || !prio);
    assign grant    = ex_ready || ld_ready;

    always_comb begin
        sel = '{addr: ld_addr, data: ld_data};
        if (ex_ready)
            sel = '{addr: ex_addr, data: ex_data};
    end

    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (ex_ready)
            prio <= 1'b0;
        else if (ld_ready)
            prio <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_wd   <= '0;
        end else if (grant) begin
            rf_we   <= (sel.addr != '0);
            rf_addr <= sel.addr;
            rf_wd   <= sel.data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cont_cnt <= '0;
        else if (both_valid && (cont_cnt != {CNTW{1'b1}}))
            cont_cnt <= cont_cnt + 1'b1;
    end

    assign q_addr[0] = q_addr_1;
    assign q_addr[1] = q_addr_2;

    genvar g;
    generate
        for (g = 0; g < NUM_Q; g++) begin : g_lookup
            rf_wb_lookup #(.ADW(ADW)) u_lookup (
                .rf_we  (rf_we),
                .rf_addr(rf_addr),
                .q_addr (q_addr[g]),
                .q_hit  (q_hit[g])
            );
        end
    endgenerate

    assign q_hit_1  = q_hit[0];
    assign q_hit_2  = q_hit[1];
    assign fwd_data = rf_wd;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a 3-bit contention counter.

module tb_rf_wb_arbiter;
    localparam int ADW  = 5;
    localparam int DPW  = 32;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ld_valid;
    logic [ADW-1:0]  ex_addr, ld_addr;
    logic [DPW-1:0]  ex_data, ld_data;
    logic            ex_ready, ld_ready;
    logic            rf_we;
    logic [ADW-1:0]  rf_addr;
    logic [DPW-1:0]  rf_wd;
    logic [ADW-1:0]  q_addr_1, q_addr_2;
    logic            q_hit_1, q_hit_2;
    logic [DPW-1:0]  fwd_data;
    logic [CNTW-1:0] cont_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    rf_wb_arbiter #(.ADW(ADW), .DPW(DPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
        .q_addr_1(q_addr_1), .q_addr_2(q_addr_2), .q_hit_1(q_hit_1), .q_hit_2(q_hit_2),
        .fwd_data(fwd_data), .cont_cnt(cont_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'hA1;
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'hB2;
        q_addr_1 = 5'd0; q_addr_2 = 5'd0;

        // Reset held two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_ex_ready", ex_ready, 1'b0);
            chk("rst_ld_ready", ld_ready, 1'b0);
            tick();
            chk("rst_rf_we", rf_we, 1'b0);
            chk("rst_rf_addr", rf_addr, 5'd0);
            chk("rst_fwd", fwd_data, 32'd0);
            chk("rst_cnt", cont_cnt, 3'd0);
            chk("rst_hit1", q_hit_1, 1'b0);
        end

        // Steady contention: ld first, then strict alternation; counter saturates at 7
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("cont_ld_ready", ld_ready, (i % 2 == 0));
            chk("cont_ex_ready", ex_ready, (i % 2 == 1));
            tick();
            chk("cont_rf_we", rf_we, 1'b1);
            chk("cont_rf_addr", rf_addr, (i % 2 == 0) ? 5'd2 : 5'd1);
            chk("cont_rf_wd", rf_wd, (i % 2 == 0) ? 32'hB2 : 32'hA1);
            chk("cont_cnt", cont_cnt, (i + 1 > 7) ? 3'd7 : 3'(i + 1));
        end

        // Single execute write with lookup and forwarding
        ld_valid = 1'b0;
        ex_addr = 5'd5; ex_data = 32'hDEAD_BEEF;
        q_addr_1 = 5'd5; q_addr_2 = 5'd9;
        #1;
        chk("single_ex_ready", ex_ready, 1'b1);
        chk("single_ld_ready", ld_ready, 1'b0);
        tick();
        chk("single_rf_we", rf_we, 1'b1);
        chk("single_rf_addr", rf_addr, 5'd5);
        chk("single_rf_wd", rf_wd, 32'hDEAD_BEEF);
        chk("single_hit1", q_hit_1, 1'b1);
        chk("single_hit2", q_hit_2, 1'b0);
        chk("single_fwd", fwd_data, 32'hDEAD_BEEF);
        chk("single_cnt_hold", cont_cnt, 3'd7);
        ex_valid = 1'b0;
        tick();
        chk("idle_rf_we", rf_we, 1'b0);
        chk("idle_hit1", q_hit_1, 1'b0);
        chk("idle_rf_addr", rf_addr, 5'd5);

        // x0 write is consumed but never issued
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h1234;
        q_addr_1 = 5'd0; q_addr_2 = 5'd0;
        #1;
        chk("x0_ld_ready", ld_ready, 1'b1);
        tick();
        chk("x0_rf_we", rf_we, 1'b0);
        chk("x0_hit1", q_hit_1, 1'b0);
        chk("x0_hit2", q_hit_2, 1'b0);
        chk("x0_rf_wd", rf_wd, 32'h1234);
        ld_valid = 1'b0;
        ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 32'h55;
        q_addr_1 = 5'd3;
        #1;
        chk("x0_next_ex_ready", ex_ready, 1'b1);
        tick();
        chk("x0_next_rf_we", rf_we, 1'b1);
        chk("x0_next_rf_addr", rf_addr, 5'd3);
        chk("x0_next_hit1", q_hit_1, 1'b1);

        // Execute write to x7, then reset with a fresh execute request held
        ex_addr = 5'd7; ex_data = 32'h77;
        tick();
        chk("pre_rst_rf_addr", rf_addr, 5'd7);
        chk("pre_rst_rf_we", rf_we, 1'b1);
        rst = 1'b1;
        ex_addr = 5'd8; ex_data = 32'h88;
        #1;
        chk("mid_rst_ex_ready", ex_ready, 1'b0);
        tick();
        chk("mid_rst_rf_we", rf_we, 1'b0);
        chk("mid_rst_cnt", cont_cnt, 3'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ex_ready", ex_ready, 1'b1);
        tick();
        chk("post_rst_rf_we", rf_we, 1'b1);
        chk("post_rst_rf_addr", rf_addr, 5'd8);
        chk("post_rst_rf_wd", rf_wd, 32'h88);

        // Load grant leaves execute favoured; next contention goes to execute
        ex_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h44;
        tick();
        chk("ld_only_rf_addr", rf_addr, 5'd4);
        ex_valid = 1'b1; ex_addr = 5'd6;
        #1;
        chk("prio_ex_ready", ex_ready, 1'b1);
        chk("prio_ld_ready", ld_ready, 1'b0);
        tick();
        chk("prio_rf_addr", rf_addr, 5'd6);
        chk("prio_cnt", cont_cnt, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
